// File: rtl/ahb_lite_master.sv
// AHB-Lite master bridge: turns a single-word command/response handshake into
// pipelined AHB-Lite NONSEQ transfers. Slot A holds the transfer currently in
// its address phase and slot D the one in its data phase. Wait states, the
// two-cycle ERROR response and a data-phase timeout (which flushes both slots)
// are all handled here.
module ahb_lite_master #(
  parameter int AddrBusWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddrBusWidth-1:0] cmd_addr,
  input  logic [DataWidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [AddrBusWidth-1:0] HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [DataWidth-1:0]    HWDATA,
  input  logic [DataWidth-1:0]    HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  // The counter only ever needs to hold values up to TimeoutCycles-1.
  localparam int CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ERR2  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;

  // Address-phase slot
  logic                    r_a_valid;
  logic                    r_a_write;
  logic [AddrBusWidth-1:0] r_a_addr;
  logic [DataWidth-1:0]    r_a_wdata;

  // Data-phase slot
  logic                    r_d_valid;
  logic                    r_d_write;
  logic [DataWidth-1:0]    r_d_wdata;

  logic [CntWidth-1:0]     r_tmo_cnt;

  logic                    r_rsp_valid;
  logic [DataWidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;

  logic                    w_run;
  logic                    w_cmd_ready;
  logic                    w_accept;
  logic                    w_tmo_hit;

  assign w_run       = (r_state == ST_RUN);
  // Slot A is free either because it is empty or because it hands off to D at this edge.
  assign w_cmd_ready = w_run && (!r_a_valid || HREADY);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_tmo_hit   = (r_tmo_cnt == CntLast);

  assign cmd_ready   = w_cmd_ready;
  assign HTRANS      = (r_a_valid && w_run) ? TransNonseq : TransIdle;
  assign HADDR       = r_a_addr;
  assign HWRITE      = r_a_write;
  assign HWDATA      = r_d_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  // Slot A: load on an accepted command, drop once handed to D or flushed.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_a_valid <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_write <= cmd_write;
      r_a_addr  <= cmd_addr;
      r_a_wdata <= cmd_wdata;
    end else if ((w_run && HREADY) || (r_state == ST_FLUSH)) begin
      r_a_valid <= 1'b0;
    end
  end

  // Control FSM: advances slot D, tracks the timeout and issues responses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state       <= ST_RUN;
      r_d_valid     <= 1'b0;
      r_d_write     <= 1'b0;
      r_d_wdata     <= '0;
      r_tmo_cnt     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; fields read as zero when idle.
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (HREADY) begin
            // Data phase completes (if any) and A advances into D.
            r_tmo_cnt <= '0;
            r_d_valid <= r_a_valid;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_wdata;
            if (r_d_valid) begin
              // HRESP with HREADY high is illegal; report it as an error completion.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= HRESP;
              r_rsp_rdata <= (r_d_write || HRESP) ? '0 : HRDATA;
            end
          end else if (r_d_valid && HRESP) begin
            // First ERROR cycle: cancel the pending address phase, keep slot A.
            r_state   <= ST_ERR2;
            r_tmo_cnt <= '0;
          end else if (r_d_valid && w_tmo_hit) begin
            // Slave stuck: abandon D now, then drain A from the FLUSH state.
            r_state       <= ST_FLUSH;
            r_tmo_cnt     <= '0;
            r_d_valid     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else if (r_d_valid) begin
            r_tmo_cnt <= r_tmo_cnt + CntWidth'(1);
          end
        end
        ST_ERR2: begin
          if (HREADY) begin
            r_state     <= ST_RUN;
            r_tmo_cnt   <= '0;
            r_d_valid   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // D was already reported on entry; only A may still be outstanding.
          r_state   <= ST_RUN;
          r_tmo_cnt <= '0;
          if (r_a_valid) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master. Each cycle the bench drives the command
// and slave-side inputs by hand and checks outputs against hand-computed values.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] t2_addr [4];
  logic [31:0] t2_data [4];

  ahb_lite_master #(
    .AddrBusWidth (32),
    .DataWidth    (32),
    .TimeoutCycles(16)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then let combinational outputs settle.
  task automatic drive(input logic cv, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic rdy, input logic resp,
                       input logic [31:0] rd);
    cmd_valid = cv;
    cmd_write = cw;
    cmd_addr  = ca;
    cmd_wdata = cd;
    HREADY    = rdy;
    HRESP     = resp;
    HRDATA    = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] trans, input logic [31:0] addr);
    chk({tag, ".htrans"}, 32'(HTRANS), 32'(trans));
    if (trans == 2'b10) chk({tag, ".haddr"}, HADDR, addr);
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic err,
                         input logic tmo, input logic [31:0] rd);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    if (v) begin
      chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(err));
      chk({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(tmo));
      chk({tag, ".rsp_rdata"}, rsp_rdata, rd);
      $display("rsp %s: rdata=0x%08h err=%0d timeout=%0d", tag, rsp_rdata, rsp_err, rsp_timeout);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t2_addr = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0400, 32'h0000_0404};
    t2_data = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};

    // ---------------- reset ----------------
    HRESET = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    chk("rst.htrans", 32'(HTRANS), 32'h0);
    chk("rst.haddr", HADDR, 32'h0);
    chk("rst.hwrite", 32'(HWRITE), 32'h0);
    chk("rst.hwdata", HWDATA, 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    HRESET = 1'b0;
    tick();

    // ---------------- T1: write then read, zero wait ----------------
    drive(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("t1.c0.ready", 32'(cmd_ready), 32'h1);
    chk_bus("t1.c0", 2'b00, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_bus("t1.c1", 2'b10, 32'h4);
    chk("t1.c1.hwrite", 32'(HWRITE), 32'h1);
    chk_rsp("t1.c1", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h1111_2222);
    chk_bus("t1.c2", 2'b00, 32'h0);
    chk("t1.c2.hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("t1.c2.ready", 32'(cmd_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t1.wr", 1'b1, 1'b0, 1'b0, 32'h0);
    chk_bus("t1.c3", 2'b10, 32'h4);
    chk("t1.c3.hwrite", 32'(HWRITE), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_rsp("t1.c4", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t1.rd", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tick();
    chk_rsp("t1.c6", 1'b0, 1'b0, 1'b0, 32'h0);

    // ---------------- T2: four back-to-back writes ----------------
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1'b1, t2_addr[i], t2_data[i], 1'b1, 1'b0, 32'hFFFF_0000);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_0000);
      if (i < 4) chk($sformatf("t2.c%0d.ready", i), 32'(cmd_ready), 32'h1);
      if (i >= 1 && i <= 4) chk_bus($sformatf("t2.c%0d", i), 2'b10, t2_addr[i-1]);
      else                  chk_bus($sformatf("t2.c%0d", i), 2'b00, 32'h0);
      if (i >= 2 && i <= 5) chk($sformatf("t2.c%0d.hwdata", i), HWDATA, t2_data[i-2]);
      chk_rsp($sformatf("t2.c%0d", i), (i >= 3 && i <= 6), 1'b0, 1'b0, 32'h0);
      tick();
    end

    // ---------------- T3: read with 3 wait states ----------------
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_bus("t3.c1", 2'b10, 32'h8);
    tick();
    for (int w = 0; w < 3; w++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hBAD0_0000);
      chk_bus($sformatf("t3.wait%0d", w), 2'b10, 32'hC);
      chk($sformatf("t3.wait%0d.ready", w), 32'(cmd_ready), 32'h0);
      chk_rsp($sformatf("t3.wait%0d", w), 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE_0008);
    chk_bus("t3.c5", 2'b10, 32'hC);
    chk_rsp("t3.c5", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hCAFE_000C);
    chk_rsp("t3.rd8", 1'b1, 1'b0, 1'b0, 32'hCAFE_0008);
    chk_bus("t3.c6", 2'b00, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t3.rdC", 1'b1, 1'b0, 1'b0, 32'hCAFE_000C);
    tick();
    chk_rsp("t3.c8", 1'b0, 1'b0, 1'b0, 32'h0);

    // ---------------- T4: ERROR response then re-issue ----------------
    drive(1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h010, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_bus("t4.c1", 2'b10, 32'h900);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    chk_bus("t4.c2", 2'b10, 32'h010);
    chk("t4.c2.ready", 32'(cmd_ready), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7777_7777);
    chk_bus("t4.err2", 2'b00, 32'h0);
    chk("t4.err2.ready", 32'(cmd_ready), 32'h0);
    chk_rsp("t4.err2", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t4.rd900", 1'b1, 1'b1, 1'b0, 32'h0);
    chk_bus("t4.reissue", 2'b10, 32'h010);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_5A5A);
    chk_rsp("t4.c5", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t4.rd010", 1'b1, 1'b0, 1'b0, 32'h0000_5A5A);
    tick();

    // ---------------- T5: timeout with a command waiting in A ----------------
    drive(1'b1, 1'b1, 32'h20, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_bus("t5.c1", 2'b10, 32'h20);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk_bus($sformatf("t5.wait%0d", k), 2'b10, 32'h24);
      chk_rsp($sformatf("t5.wait%0d", k), 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_rsp("t5.wr20", 1'b1, 1'b1, 1'b1, 32'h0);
    chk_bus("t5.flush", 2'b00, 32'h0);
    chk("t5.flush.ready", 32'(cmd_ready), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_rsp("t5.rd24", 1'b1, 1'b1, 1'b1, 32'h0);
    chk_bus("t5.after", 2'b00, 32'h0);
    chk("t5.after.ready", 32'(cmd_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_rsp("t5.quiet", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // ---------------- T6: reset during the third wait state ----------------
    drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h34, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk_bus("t6.prerst", 2'b10, 32'h34);
    HRESET = 1'b1;
    #1;
    chk("t6.rst.htrans", 32'(HTRANS), 32'h0);
    chk("t6.rst.haddr", HADDR, 32'h0);
    chk("t6.rst.hwrite", 32'(HWRITE), 32'h0);
    chk("t6.rst.rsp_valid", 32'(rsp_valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (2) begin
      tick();
      chk_rsp("t6.inrst", 1'b0, 1'b0, 1'b0, 32'h0);
    end
    HRESET = 1'b0;
    for (int q = 0; q < 3; q++) begin
      tick();
      chk_rsp($sformatf("t6.post%0d", q), 1'b0, 1'b0, 1'b0, 32'h0);
    end
    drive(1'b1, 1'b1, 32'h40, 32'h0000_1234, 1'b1, 1'b0, 32'h0);
    chk("t6.new.ready", 32'(cmd_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_bus("t6.new", 2'b10, 32'h40);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t6.new.hwdata", HWDATA, 32'h0000_1234);
    tick();
    chk_rsp("t6.wr40", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite master bridge that converts a simple single-word command/response interface into pipelined AHB-Lite transfers.
- Sits directly upstream of the slave top and drives the shared AHB interface: HADDR, HTRANS, HWRITE, HWDATA out; HRDATA, HREADY, HRESP in.
- Supports one transfer in address phase overlapped with one transfer in data phase.
- Handles wait states, the two-cycle ERROR response and a wait-state timeout.

Parameters:
AddrBusWidth, 32, width of HADDR and cmd_addr
DataWidth, 32, width of HWDATA/HRDATA/cmd_wdata/rsp_rdata
TimeoutCycles, 16, consecutive HREADY-low data-phase cycles before abort (>=2)

Ports:
HCLK  in  1  bus clock; all state updates on rising edge
HRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AddrBusWidth  word address
cmd_wdata  in  DataWidth  write data
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_rdata  out  DataWidth  read data (0 for writes/errors)
rsp_err  out  1  transfer ended with ERROR or timeout
rsp_timeout  out  1  error cause was timeout
HADDR  out  AddrBusWidth  address-phase address
HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only
HWRITE  out  1  address-phase direction
HWDATA  out  DataWidth  data-phase write data
HRDATA  in  DataWidth  read data
HREADY  in  1  transfer complete / wait state
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async assert, sync release):
  - HTRANS=IDLE; HADDR, HWRITE, HWDATA, rsp_* = 0.
  - Both pipeline slots invalid; timeout counter=0; state=RUN.
  - Reset mid-transfer drops all outstanding commands; no responses are issued.
- Two register slots:
  - A (address phase): valid, write, addr, wdata.
  - D (data phase): valid, write, wdata.
- HTRANS=NONSEQ iff A.valid and state=RUN; otherwise IDLE. HADDR/HWRITE come from slot A; HWDATA comes from slot D.
- cmd_ready = (state==RUN) && (!A.valid || HREADY). This is combinational from HREADY and registers.
- Accepted command loads slot A at that edge, so address phase begins the next cycle. Accept-to-NONSEQ latency is 1 cycle.
- Edge with HREADY=1 and state=RUN:
  - A moves to D (or D is cleared if A is empty).
  - If D was valid, it completes: the next cycle rsp_valid=1, rsp_rdata=HRDATA (reads) or 0 (writes), rsp_err=0.
  - Back-to-back commands therefore sustain one transfer per cycle with no wait states.
- HREADY=0 with HRESP=0: all slots hold; timeout counter increments while D.valid. The counter clears on any HREADY=1 edge.
- States:
  - RUN → ERR2: on edge with D.valid, HRESP=1, HREADY=0 (first ERROR cycle). In ERR2, HTRANS=IDLE; slot A is retained, not lost.
  - ERR2 → RUN: on edge with HREADY=1. D completes with rsp_valid=1, rsp_err=1, rsp_rdata=0. Slot A re-issues NONSEQ the following cycle.
  - RUN → FLUSH: when the timeout counter reaches TimeoutCycles-1 and HREADY=0. In FLUSH, HTRANS=IDLE.
  - FLUSH: the D response (err=1, timeout=1) is issued in the next cycle. If A was valid, its response (err=1, timeout=1) follows in the cycle after.
  - FLUSH → RUN: once both slots are empty. The counter clears.
- HRESP=1 with HREADY=1 in RUN is a protocol violation: treat as ERROR completion of D (rsp_err=1).
- Responses are strictly in command order; at most one rsp_valid pulse per cycle.
- HRDATA is sampled only on data-phase completion edges.

Test Plan:
1. Reset then write 0x0000_0004 ← 0xDEAD_BEEF, then read 0x0000_0004, zero-wait slave → NONSEQ one cycle after accept; read rsp_rdata=0xDEAD_BEEF, rsp_err=0, read response 2 cycles after write response.
2. Four back-to-back writes to 0x000, 0x004, 0x400, 0x404 with cmd_valid held high → cmd_ready stays 1; four consecutive NONSEQ cycles; four responses with err=0 on consecutive cycles.
3. Read 0x0000_0008 with slave inserting 3 wait states → HADDR/HTRANS stable during waits; rsp_valid exactly once, 4 cycles after data phase starts, with correct data.
4. Read 0x0000_0900 (out of range, default slave) followed by read 0x0000_0010 → ERR2 entered; HTRANS=IDLE next cycle; response 1 err=1; 0x010 re-issued and returns err=0.
5. Slave holds HREADY=0 indefinitely, TimeoutCycles=16, with one command pending in A → after 16 wait cycles, two responses err=1, timeout=1 in order; bus returns to IDLE; cmd_ready=1 afterwards.
6. Assert HRESET during the third wait state of a read → outputs zero immediately (asynchronous); no rsp_valid ever issued; next command works normally.
